// File: rtl/scan_addr_gen_if.sv
// Handshake/bus bundle for scan_addr_gen. The dir signal exists only when SCAN_DOWN_EN is defined.
interface scan_addr_gen_if #(
    parameter int unsigned PRESCALE_W = 16
);
    logic                  en;
    logic                  load;
    logic [2:0]            load_val;
    logic [PRESCALE_W-1:0] div;
`ifdef SCAN_DOWN_EN
    logic                  dir;
`endif
    logic [2:0]            addr;
    logic                  tick;
    logic                  frame;

`ifdef SCAN_DOWN_EN
    modport master (output en, load, load_val, div, dir, input addr, tick, frame);
    modport slave  (input en, load, load_val, div, dir, output addr, tick, frame);
`else
    modport master (output en, load, load_val, div, input addr, tick, frame);
    modport slave  (input en, load, load_val, div, output addr, tick, frame);
`endif
endinterface

// File: rtl/scan_addr_gen.sv
// Prescaled 3-bit scan address generator for a 3-to-8 decoder, with tick/frame pulses.
// Optional macro SCAN_DOWN_EN adds the dir input and down-counting with 0->7 wrap.
module scan_addr_gen #(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic           clk,
    input  logic           resetn,
    scan_addr_gen_if.slave bus
);
    localparam int unsigned AW = 3;

    logic [PRESCALE_W-1:0] pc_q, pc_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic                  tick_q, tick_d;
    logic                  frame_q, frame_d;
    logic                  step_down;

`ifdef SCAN_DOWN_EN
    assign step_down = bus.dir;
`else
    assign step_down = 1'b0;
`endif

    // Next-state: load beats everything; an advance fires once pc has reached div
    always_comb begin
        pc_d    = pc_q;
        addr_d  = addr_q;
        tick_d  = 1'b0;
        frame_d = 1'b0;
        if (bus.load) begin
            addr_d = bus.load_val;
            pc_d   = '0;
        end else if (bus.en) begin
            if (pc_q >= bus.div) begin
                pc_d   = '0;
                tick_d = 1'b1;
                if (step_down) begin
                    addr_d  = addr_q - AW'(1);
                    frame_d = (addr_q == AW'(0));
                end else begin
                    addr_d  = addr_q + AW'(1);
                    frame_d = (addr_q == AW'(7));
                end
            end else begin
                pc_d = pc_q + PRESCALE_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            pc_q    <= '0;
            addr_q  <= '0;
            tick_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            tick_q  <= tick_d;
            frame_q <= frame_d;
        end
    end

    assign bus.addr  = addr_q;
    assign bus.tick  = tick_q;
    assign bus.frame = frame_q;
endmodule
